// File: rtl/ram_rd_pkg.sv
// ram_rd_pkg: shared types and sizing for the RAM stream reader
`define RD_BEAT_T(W) struct packed { logic last; logic [(W)-1:0] data; }
package ram_rd_pkg;
  localparam int FIFO_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/ram_rd_fifo.sv
// ram_rd_fifo: first-word-fall-through FIFO; DEPTH must be a power of two
module ram_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst reader from a registered-read RAM onto a valid/ready stream
module ram_stream_reader import ram_rd_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);
  typedef `RD_BEAT_T(DATA_WIDTH) rd_beat_t;
  rd_state_t state, state_n;
  rd_beat_t head;
  logic [ADDR_WIDTH-1:0] addr, cur_addr;
  logic [ADDR_WIDTH:0] rem, cur_rem;
  logic [$clog2(FIFO_DEPTH+1)-1:0] count;
  logic p1, p2, p1_last, p2_last, pop, full, empty, start_ok, issue;
  assign ram_we = 1'b0;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign m_valid = !empty;
  assign m_data = head.data;
  assign m_last = !empty && head.last;
  assign pop = m_valid && m_ready;
  assign start_ok = state == IDLE && start && |length;
  assign cur_addr = start_ok ? base_addr : addr;
  assign cur_rem = start_ok ? length : rem;
  // The first read goes out on the start edge itself; later ones only when a FIFO slot is reserved.
  assign issue = start_ok || (state == RUN && |rem &&
                 (4'(count) + 4'(p1) + 4'(p2)) < (4'(FIFO_DEPTH) + 4'(pop)));
  always_comb
    state_n = state == IDLE  ? (start ? (|length ? RUN : DONE) : IDLE) :
              state == RUN   ? (|rem ? RUN : DRAIN) :
              state == DRAIN ? (pop && m_last ? DONE : DRAIN) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      rem <= '0;
      ram_addr <= '0;
      p1 <= 1'b0;
      p2 <= 1'b0;
      p1_last <= 1'b0;
      p2_last <= 1'b0;
    end else begin
      p1 <= issue;
      p2 <= p1;
      p2_last <= p1_last;
      if (issue) begin
        ram_addr <= cur_addr;
        addr <= cur_addr + 1'b1;
        rem <= cur_rem - 1'b1;
        p1_last <= cur_rem == (ADDR_WIDTH+1)'(1);
      end
    end
  ram_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(rd_beat_t))) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(p2 && (!full || pop)),
    .pop(pop),
    .din({p2_last, ram_q}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed bursts checked against a beat-queue model of the reader
module tb_ram_stream_reader;
  localparam int DW = 8, AW = 8;
  logic clk = 0, rst_n = 0, start = 0, m_ready = 1;
  logic [AW-1:0] base_addr = 0, ram_addr;
  logic [AW:0] length = 0;
  logic [DW-1:0] ram_q, m_data;
  logic busy, done, ram_we, m_valid, m_last;
  logic [DW-1:0] mem [2**AW];
  int checks = 0, errors = 0, cyc = 0, phase = 0, nx = 0, ndone = 0, nlast = 0, last_at = 0, done_cyc = 0, rdy_mode = 0;
  logic [DW-1:0] got [$];
  int xcyc [$];
  logic [DW:0] q [$];
  logic [AW-1:0] alog [$];
  logic stall = 0, pl = 0;
  logic [DW-1:0] pd = 0;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 burst active, 2 done cycle; q holds the beats still owed.
  task automatic monitor();
    logic x, lastx;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        phase = 0;
        stall = 0;
      end else begin
        chk("busy", busy, phase == 1);
        chk("done", done, phase == 2);
        chk("ram_we", ram_we, 0);
        chk("fifo_occ_le4", dut.u_fifo.count <= 4, 1);
        chk("last_without_valid", m_last && !m_valid, 0);
        if (m_valid && q.size() == 0) chk("valid_unexpected", m_valid, 0);
        if (stall) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, pd);
          chk("stall_last", m_last, pl);
        end
        if (done) begin ndone++; done_cyc = cyc; end
        if (alog.size() == 0 || alog[$] != ram_addr) alog.push_back(ram_addr);
        x = m_valid && m_ready && q.size() != 0;
        lastx = 0;
        if (x) begin
          chk("beat_data", m_data, q[0][DW-1:0]);
          chk("beat_last", m_last, q[0][DW]);
          got.push_back(m_data);
          xcyc.push_back(cyc);
          nx++;
          if (m_last) begin nlast++; last_at = nx; end
          lastx = q[0][DW];
          void'(q.pop_front());
        end
        stall = m_valid && !m_ready;
        pd = m_data;
        pl = m_last;
        if (phase == 2) phase = 0;
        else if (phase == 1 && lastx) phase = 2;
        else if (phase == 0 && start) begin
          if (length == 0) phase = 2;
          else begin
            phase = 1;
            for (int i = 0; i < length; i++) q.push_back({i == length - 1, mem[AW'(base_addr + i)]});
          end
        end
      end
    end
  endtask

  task automatic drive_ready();
    logic [5:0] pat = 6'b101001;
    int k = 0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? pat[k % 6] : 1'($urandom_range(0, 1));
      k++;
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(int b, int l);
    base_addr = AW'(b);
    length = (AW+1)'(l);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(int lim);
    int k = 0;
    while (!done && k < lim) begin tick(); k++; end
    chk("done_timeout", done, 1);
    tick();
  endtask

  task automatic check_zero(string n);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_ram_addr"}, ram_addr, 0);
    chk({n, "_m_valid"}, m_valid, 0);
    chk({n, "_m_last"}, m_last, 0);
    chk({n, "_m_data"}, m_data, 0);
  endtask

  task automatic run_tests();
    int n0, s0, d0, l0, k;
    for (int i = 0; i < 2**AW; i++) mem[i] = 8'(i) ^ 8'h5a;
    #3 check_zero("reset");
    chk("reset_ram_we", ram_we, 0);
    tick(2);
    rst_n = 1;
    tick();
    // 1: basic burst, full rate
    for (int i = 0; i < 4; i++) mem[10 + i] = 8'hA0 + 8'(i);
    n0 = nx; l0 = nlast;
    go(10, 4);
    s0 = cyc;
    chk("t1_valid_e0", m_valid, 0);
    tick();
    chk("t1_valid_e1", m_valid, 0);
    tick();
    chk("t1_valid_e2", m_valid, 1);
    wait_done(20);
    chk("t1_count", nx - n0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", got[n0 + i], 8'hA0 + i);
      chk("t1_cycle", xcyc[n0 + i], s0 + 2 + i);
    end
    chk("t1_last", last_at - n0, 4);
    chk("t1_nlast", nlast - l0, 1);
    chk("t1_done_cycle", done_cyc, s0 + 6);
    // 2: same burst under a stalling sink
    rdy_mode = 1;
    n0 = nx;
    go(10, 4);
    wait_done(60);
    rdy_mode = 0;
    chk("t2_count", nx - n0, 4);
    for (int i = 0; i < 4; i++) chk("t2_data", got[n0 + i], 8'hA0 + i);
    // 3: address wrap
    mem[254] = 8'h11; mem[255] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
    n0 = nx;
    go(254, 4);
    alog.delete();
    wait_done(30);
    chk("t3_count", nx - n0, 4);
    chk("t3_d0", got[n0], 8'h11);
    chk("t3_d1", got[n0 + 1], 8'h22);
    chk("t3_d2", got[n0 + 2], 8'h33);
    chk("t3_d3", got[n0 + 3], 8'h44);
    chk("t3_alog_size", alog.size(), 4);
    if (alog.size() >= 4) begin
      chk("t3_a0", alog[0], 254);
      chk("t3_a1", alog[1], 255);
      chk("t3_a2", alog[2], 0);
      chk("t3_a3", alog[3], 1);
    end
    // 4: zero length, then start ignored mid-burst
    n0 = nx;
    go(5, 0);
    chk("t4_zero_done", done, 1);
    chk("t4_zero_busy", busy, 0);
    chk("t4_zero_valid", m_valid, 0);
    tick();
    chk("t4_zero_done_end", done, 0);
    chk("t4_zero_busy_end", busy, 0);
    chk("t4_zero_beats", nx - n0, 0);
    d0 = ndone;
    go(20, 8);
    tick(2);
    go(40, 8);
    wait_done(40);
    tick(2);
    chk("t4_beats", nx - n0, 8);
    chk("t4_dones", ndone - d0, 1);
    chk("t4_first", got[n0], 8'h4e);
    chk("t4_final", got[n0 + 7], 8'h41);
    // 5: reset mid-burst, then a clean short burst
    n0 = nx;
    go(0, 16);
    k = 0;
    while (nx < n0 + 3 && k < 50) begin tick(); k++; end
    chk("t5_three_beats", nx >= n0 + 3, 1);
    #2 rst_n = 0;
    #1 check_zero("t5_reset");
    tick(2);
    rst_n = 1;
    tick();
    n0 = nx;
    go(0, 2);
    wait_done(20);
    tick(2);
    chk("t5_count", nx - n0, 2);
    chk("t5_d0", got[n0], 8'h33);
    chk("t5_d1", got[n0 + 1], 8'h44);
    // 6: whole memory, random contents and random sink
    for (int i = 0; i < 2**AW; i++) mem[i] = 8'($urandom);
    rdy_mode = 2;
    n0 = nx; l0 = nlast;
    go(0, 256);
    wait_done(3000);
    rdy_mode = 0;
    chk("t6_count", nx - n0, 256);
    chk("t6_nlast", nlast - l0, 1);
    chk("t6_last_pos", last_at - n0, 256);
    chk("model_drained", q.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      drive_ready();
      run_tests();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
